// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single bram_controller port.
// A grant is held until the slave answers, or until a watchdog forces an error completion.
module mem_bus_arbiter #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                m0_mem_valid,
  output logic                m0_mem_ready,
  input  logic [ADDR_W-1:0]   m0_mem_addr,
  input  logic [DATA_W-1:0]   m0_mem_wdata,
  input  logic [DATA_W/8-1:0] m0_mem_wstrb,
  output logic [DATA_W-1:0]   m0_mem_rdata,

  input  logic                m1_mem_valid,
  output logic                m1_mem_ready,
  input  logic [ADDR_W-1:0]   m1_mem_addr,
  input  logic [DATA_W-1:0]   m1_mem_wdata,
  input  logic [DATA_W/8-1:0] m1_mem_wstrb,
  output logic [DATA_W-1:0]   m1_mem_rdata,

  output logic                s_mem_valid,
  input  logic                s_mem_ready,
  output logic [ADDR_W-1:0]   s_mem_addr,
  output logic [DATA_W-1:0]   s_mem_wdata,
  output logic [DATA_W/8-1:0] s_mem_wstrb,
  input  logic [DATA_W-1:0]   s_mem_rdata,

  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic [TMR_W-1:0]   timer_q;

  logic own0, own1, owner_valid, slave_done, tmo_hit, finish;

  always_comb begin
    own0        = (state_q == GNT0);
    own1        = (state_q == GNT1);
    owner_valid = (own0 & m0_mem_valid) | (own1 & m1_mem_valid);
    slave_done  = owner_valid & s_mem_ready;
    // A slave answer on the last watchdog cycle still counts as a normal completion.
    tmo_hit     = owner_valid & ~s_mem_ready & (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    finish      = slave_done | tmo_hit;
  end

  always_comb begin
    grant        = {own1, own0};
    timeout_err  = tmo_hit;
    s_mem_valid  = owner_valid & ~tmo_hit;
    s_mem_addr   = own0 ? m0_mem_addr  : (own1 ? m1_mem_addr  : '0);
    s_mem_wdata  = own0 ? m0_mem_wdata : (own1 ? m1_mem_wdata : '0);
    s_mem_wstrb  = own0 ? m0_mem_wstrb : (own1 ? m1_mem_wstrb : '0);
    m0_mem_ready = own0 & finish;
    m1_mem_ready = own1 & finish;
    m0_mem_rdata = own0 ? (tmo_hit ? ERR_RDATA : s_mem_rdata) : '0;
    m1_mem_rdata = own1 ? (tmo_hit ? ERR_RDATA : s_mem_rdata) : '0;
  end

  // Every completion returns through IDLE so the slave always sees valid drop between requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (m0_mem_valid && m1_mem_valid) begin
            state_q <= last_grant_q ? GNT0 : GNT1;
          end else if (m0_mem_valid) begin
            state_q <= GNT0;
          end else if (m1_mem_valid) begin
            state_q <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (!owner_valid) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (finish) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            last_grant_q <= (state_q == GNT1);
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: bench-side BRAM slave, transaction-level arbitration model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

  localparam int TMO = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } tx_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_mem_valid, m1_mem_valid;
  logic        m0_mem_ready, m1_mem_ready;
  logic [31:0] m0_mem_addr, m1_mem_addr, m0_mem_wdata, m1_mem_wdata;
  logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
  logic [31:0] m0_mem_rdata, m1_mem_rdata;
  logic        s_mem_valid;
  logic        s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_mem_valid(m0_mem_valid), .m0_mem_ready(m0_mem_ready), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_ready(m1_mem_ready), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_ready(s_mem_ready), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_rdata(s_mem_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  function automatic logic [31:0] initWord(int i);
    return (i == 0) ? 32'h0000_0081 : 32'h1000_0000 + 32'(i);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM slave: answers slaveLat cycles after it first sees valid, or never when muted.
  logic [31:0] slaveMem [0:15];
  bit          memInit = 1'b0;
  int          slaveLat = 1;
  bit          slaveMute = 1'b0;
  int          slaveCnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_mem_ready <= 1'b0;
      s_mem_rdata <= '0;
      slaveCnt    <= 0;
      if (!memInit) begin
        for (int i = 0; i < 16; i++) slaveMem[i] <= initWord(i);
        memInit <= 1'b1;
      end
    end else if (s_mem_ready) begin
      s_mem_ready <= 1'b0;
      slaveCnt    <= 0;
    end else if (s_mem_valid && !slaveMute) begin
      if (slaveCnt >= slaveLat - 1) begin
        s_mem_ready <= 1'b1;
        s_mem_rdata <= slaveMem[s_mem_addr[5:2]];
        for (int b = 0; b < 4; b++)
          if (s_mem_wstrb[b]) slaveMem[s_mem_addr[5:2]][8*b +: 8] <= s_mem_wdata[8*b +: 8];
        slaveCnt <= 0;
      end else begin
        slaveCnt <= slaveCnt + 1;
      end
    end else begin
      slaveCnt <= 0;
    end
  end

  // Reference model: who owns the bus, who won last, how long the current owner has waited.
  int          mOwner = -1;
  int          mLast = 1;
  int          mCnt = 0;
  logic [31:0] shadow [0:15];
  logic [1:0]  eGrant;
  logic        eSv, eTmo, eR0, eR1, ov;
  logic [31:0] eAddr, eWd, eRd;
  logic [3:0]  eSt;
  int          own;

  logic [31:0] rx0 [$];
  logic [31:0] rx1 [$];
  logic [1:0]  grantLog [$];
  logic [1:0]  prevGrant = 2'b00;
  int          tmoCount = 0;
  int          heldCnt = 0;
  int          lastHeld = 0;

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = initWord(i);
    forever begin
      @(negedge clk);
      eGrant = 2'b00; eSv = 1'b0; eTmo = 1'b0; eR0 = 1'b0; eR1 = 1'b0;
      eAddr = '0; eWd = '0; eSt = '0; eRd = '0; own = mOwner;
      if (!reset_n) begin
        mOwner = -1; mLast = 1; mCnt = 0; own = -1;
      end else if (mOwner < 0) begin
        if (m0_mem_valid && m1_mem_valid) mOwner = 1 - mLast;
        else if (m0_mem_valid)            mOwner = 0;
        else if (m1_mem_valid)            mOwner = 1;
      end else begin
        ov     = (own == 0) ? m0_mem_valid : m1_mem_valid;
        eAddr  = (own == 0) ? m0_mem_addr  : m1_mem_addr;
        eWd    = (own == 0) ? m0_mem_wdata : m1_mem_wdata;
        eSt    = (own == 0) ? m0_mem_wstrb : m1_mem_wstrb;
        eGrant = (own == 0) ? 2'b01 : 2'b10;
        eRd    = s_mem_rdata;
        if (!ov) begin
          mOwner = -1; mCnt = 0;
        end else if (s_mem_ready) begin
          eSv = 1'b1;
          eRd = shadow[eAddr[5:2]];
          for (int b = 0; b < 4; b++)
            if (eSt[b]) shadow[eAddr[5:2]][8*b +: 8] = eWd[8*b +: 8];
          if (own == 0) eR0 = 1'b1; else eR1 = 1'b1;
          mLast = own; mOwner = -1; mCnt = 0;
        end else if (mCnt == TMO - 1) begin
          eRd = 32'hDEAD_BEEF; eTmo = 1'b1;
          if (own == 0) eR0 = 1'b1; else eR1 = 1'b1;
          mLast = own; mOwner = -1; mCnt = 0;
        end else begin
          eSv = 1'b1;
          mCnt++;
        end
      end
      checkOutput("grant", {30'd0, grant}, {30'd0, eGrant});
      checkOutput("s_mem_valid", {31'd0, s_mem_valid}, {31'd0, eSv});
      checkOutput("s_mem_addr", s_mem_addr, eAddr);
      checkOutput("s_mem_wdata", s_mem_wdata, eWd);
      checkOutput("s_mem_wstrb", {28'd0, s_mem_wstrb}, {28'd0, eSt});
      checkOutput("m0_mem_ready", {31'd0, m0_mem_ready}, {31'd0, eR0});
      checkOutput("m1_mem_ready", {31'd0, m1_mem_ready}, {31'd0, eR1});
      checkOutput("m0_mem_rdata", m0_mem_rdata, (own == 0) ? eRd : 32'd0);
      checkOutput("m1_mem_rdata", m1_mem_rdata, (own == 1) ? eRd : 32'd0);
      checkOutput("timeout_err", {31'd0, timeout_err}, {31'd0, eTmo});

      if (m0_mem_ready) rx0.push_back(m0_mem_rdata);
      if (m1_mem_ready) rx1.push_back(m1_mem_rdata);
      if (grant != 2'b00 && grant != prevGrant) grantLog.push_back(grant);
      prevGrant = grant;
      heldCnt = (grant != 2'b00) ? heldCnt + 1 : 0;
      if (m0_mem_ready || m1_mem_ready) lastHeld = heldCnt;
      if (timeout_err) tmoCount++;
    end
  end

  tx_t q0 [$];
  tx_t q1 [$];

  // Masters hold valid until their ready pulse, then start the next queued transfer at once.
  task automatic runQueues(int budget);
    int  n = 0;
    bit  r0, r1;
    tx_t t;
    while ((q0.size() > 0 || q1.size() > 0 || m0_mem_valid || m1_mem_valid) && n < budget) begin
      if (!m0_mem_valid && q0.size() > 0) begin
        t = q0.pop_front();
        m0_mem_addr = t.addr; m0_mem_wdata = t.wdata; m0_mem_wstrb = t.wstrb; m0_mem_valid = 1'b1;
      end
      if (!m1_mem_valid && q1.size() > 0) begin
        t = q1.pop_front();
        m1_mem_addr = t.addr; m1_mem_wdata = t.wdata; m1_mem_wstrb = t.wstrb; m1_mem_valid = 1'b1;
      end
      @(negedge clk);
      r0 = m0_mem_ready;
      r1 = m1_mem_ready;
      @(posedge clk); #1;
      if (r0) begin m0_mem_valid = 1'b0; m0_mem_addr = '0; m0_mem_wdata = '0; m0_mem_wstrb = '0; end
      if (r1) begin m1_mem_valid = 1'b0; m1_mem_addr = '0; m1_mem_wdata = '0; m1_mem_wstrb = '0; end
      n++;
    end
    if (n >= budget) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL runQueues_timeout: got %0d cycles, expected fewer than %0d", n, budget);
      m0_mem_valid = 1'b0; m1_mem_valid = 1'b0;
      q0.delete(); q1.delete();
    end
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus();
    int b0, b1, g, t0;
    int expSeq [6] = '{1, 2, 1, 2, 1, 2};

    m0_mem_valid = 1'b0; m0_mem_addr = '0; m0_mem_wdata = '0; m0_mem_wstrb = '0;
    m1_mem_valid = 1'b0; m1_mem_addr = '0; m1_mem_wdata = '0; m1_mem_wstrb = '0;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("rst_grant", {30'd0, grant}, 32'd0);
    checkOutput("rst_s_valid", {31'd0, s_mem_valid}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout_err}, 32'd0);
    checkOutput("rst_m0_rdata", m0_mem_rdata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Lone m0 read of word 0.
    b0 = rx0.size(); b1 = rx1.size();
    q0.push_back('{32'h0, 32'h0, 4'h0});
    runQueues(50);
    checkOutput("t1_m0_count", rx0.size() - b0, 1);
    checkOutput("t1_m0_rdata", rx0[b0], 32'h81);
    checkOutput("t1_m1_count", rx1.size() - b1, 0);
    checkOutput("t1_grant_cycles", lastHeld, 2);

    // Simultaneous requests straight after reset: m0 write then m1 read-back.
    resetDut();
    b1 = rx1.size(); g = grantLog.size();
    q0.push_back('{32'h4, 32'h1234_5678, 4'hF});
    q1.push_back('{32'h4, 32'h0, 4'h0});
    runQueues(50);
    checkOutput("t2_first_grant", {30'd0, grantLog[g]}, 32'd1);
    checkOutput("t2_second_grant", {30'd0, grantLog[g+1]}, 32'd2);
    checkOutput("t2_m1_rdata", rx1[b1], 32'h1234_5678);

    // Continuous requests from both: strict alternation.
    b0 = rx0.size(); b1 = rx1.size(); g = grantLog.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{32'(8 + 4*i), 32'h0, 4'h0});
      q1.push_back('{32'(20 + 4*i), 32'h0, 4'h0});
    end
    runQueues(200);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t3_grant%0d", i), {30'd0, grantLog[g+i]}, 32'(expSeq[i]));
    checkOutput("t3_m0_count", rx0.size() - b0, 3);
    checkOutput("t3_m1_count", rx1.size() - b1, 3);

    // Silent slave: watchdog completes m1 with the error word.
    slaveMute = 1'b1;
    b1 = rx1.size(); t0 = tmoCount;
    q1.push_back('{32'h8, 32'h0, 4'h0});
    runQueues(60);
    slaveMute = 1'b0;
    checkOutput("t4_tmo_count", tmoCount - t0, 1);
    checkOutput("t4_m1_rdata", rx1[b1], 32'hDEAD_BEEF);
    checkOutput("t4_grant_cycles", lastHeld, TMO);
    g = grantLog.size();
    q0.push_back('{32'h0, 32'h0, 4'h0});
    q1.push_back('{32'h0, 32'h0, 4'h0});
    runQueues(50);
    checkOutput("t4_next_tie", {30'd0, grantLog[g]}, 32'd1);

    // Slave answers on the final watchdog cycle: normal completion wins.
    slaveLat = TMO - 1;
    b0 = rx0.size(); t0 = tmoCount;
    q0.push_back('{32'h0, 32'h0, 4'h0});
    runQueues(60);
    checkOutput("t5_tmo_count", tmoCount - t0, 0);
    checkOutput("t5_m0_rdata", rx0[b0], 32'h81);
    checkOutput("t5_grant_cycles", lastHeld, TMO);

    // Asynchronous reset in the middle of an m0 grant.
    slaveLat = 5;
    m0_mem_addr = 32'hC; m0_mem_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2 checkOutput("t6_pre_grant", {30'd0, grant}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_s_valid", {31'd0, s_mem_valid}, 32'd0);
    checkOutput("t6_rst_m0_ready", {31'd0, m0_mem_ready}, 32'd0);
    checkOutput("t6_rst_grant", {30'd0, grant}, 32'd0);
    m0_mem_valid = 1'b0; m0_mem_addr = '0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    slaveLat = 1;
    g = grantLog.size();
    q0.push_back('{32'h4, 32'h0, 4'h0});
    q1.push_back('{32'h8, 32'h0, 4'h0});
    runQueues(50);
    checkOutput("t6_first_after_reset", {30'd0, grantLog[g]}, 32'd1);
  endtask

  initial begin
    applyStimulus();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares a single bram_controller memory port between two requesters using the same valid/ready/addr/wdata/wstrb/rdata bus, so a CPU core and a DMA/test sequencer can both reach BRAM. The arbiter is round-robin, and a grant is held until the slave returns mem_ready. A watchdog timer ends a stuck transaction with an error response, so a requester never hangs.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width on all ports (wstrb width = DATA_W/8)
TIMEOUT_CYCLES, 1024, cycles in a grant state without s_mem_ready before forced completion; must be >= 2
ERR_RDATA, 32'hDEAD_BEEF, rdata returned to the requester on timeout

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_mem_valid  in  1  requester 0 request; held until m0_mem_ready
m0_mem_ready  out  1  requester 0 completion pulse (1 cycle)
m0_mem_addr  in  ADDR_W  requester 0 byte address
m0_mem_wdata  in  DATA_W  requester 0 write data
m0_mem_wstrb  in  DATA_W/8  requester 0 byte enables; 0 = read
m0_mem_rdata  out  DATA_W  requester 0 read data
m1_mem_valid, m1_mem_ready, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb, m1_mem_rdata  same as m0 for requester 1
s_mem_valid  out  1  to bram_controller mem_valid
s_mem_ready  in  1  from bram_controller mem_ready
s_mem_addr  out  ADDR_W  to bram_controller
s_mem_wdata  out  DATA_W  to bram_controller
s_mem_wstrb  out  DATA_W/8  to bram_controller
s_mem_rdata  in  DATA_W  from bram_controller
grant  out  2  one-hot current owner (bit0 = m0), 0 when idle
timeout_err  out  1  one-cycle pulse when a transaction is forced complete

Behaviour:
- Reset (async assert, sync release): state = IDLE, last_grant = 1 (m0 wins the first tie), timer = 0, grant = 0, timeout_err = 0.
- During reset: s_mem_valid, m*_mem_ready, m*_mem_rdata all read 0.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - Only m0 valid -> GNT0; only m1 valid -> GNT1.
  - Both valid -> the requester that is not last_grant.
  - The transition is registered, so a request seen in cycle N is granted in N+1.
  - s_mem_ready in IDLE is ignored.
- GNTx:
  - grant = one-hot x.
  - s_mem_valid = mx_mem_valid.
  - s_mem_addr / wdata / wstrb = mx_* (combinational mux).
  - Non-owner: ready = 0, rdata = 0.
  - Owner rdata = s_mem_rdata.
- Completion:
  - In GNTx with s_mem_ready = 1: mx_mem_ready = 1 in the same cycle (combinational passthrough).
  - Next state = IDLE, last_grant <= x, timer <= 0.
- Mandatory idle: at least one IDLE cycle between transactions, so s_mem_valid is low for >= 1 cycle and the bram_controller sees a fresh request. Continuous requests from both masters therefore alternate m0, m1, m0, ...
- Timer:
  - Increments each GNTx cycle without s_mem_ready.
  - When timer == TIMEOUT_CYCLES-1 and s_mem_ready = 0: mx_mem_ready = 1, mx_mem_rdata = ERR_RDATA, timeout_err = 1 (same cycle), s_mem_valid forced 0 that cycle, next state = IDLE, last_grant <= x.
  - If s_mem_ready and the timeout coincide, the normal completion wins and timeout_err stays 0.
- Abort: in GNTx with mx_mem_valid = 0 (protocol violation), go to IDLE next cycle with no ready pulse and no last_grant update; timer cleared.
- Idle outputs: s_mem_addr / wdata / wstrb = 0.
- Reset mid-transaction: outputs drop to reset values immediately (async). The bram_controller is reset from the same reset_n.
- Latency:
  - Arbitration adds exactly 1 cycle (IDLE -> GNT) ahead of the slave latency.
  - Total per transfer = 1 + slave latency, plus 1 IDLE cycle before the next grant.
- No combinational path from m*_mem_valid to grant; grant and state are registered.

Test Plan:
1. m0 read, addr 0x0 (BRAM word 0 = 0x81), m1 idle -> grant = 01 one cycle after valid; s_mem_addr = 0; m0_mem_ready pulses once with m0_mem_rdata = 0x81; m1_mem_ready never asserts.
2. m0 and m1 assert valid in the same cycle after reset (m0 write 0x4 <= 0x12345678 wstrb = 4'hF, m1 read 0x4) -> m0 granted first, IDLE gap, then m1 granted and reads 0x12345678.
3. Both hold valid for 6 back-to-back transactions -> grant sequence 01, 00, 10, 00, 01, ...; three completions each; s_mem_valid low >= 1 cycle between transfers.
4. Slave model never asserts ready, TIMEOUT_CYCLES = 16, m1 read -> m1_mem_ready plus timeout_err exactly 16 cycles after grant; m1_mem_rdata = 0xDEADBEEF; next tie goes to m0.
5. Slave ready arrives on the exact cycle timer == 15 -> normal completion with slave rdata; timeout_err = 0.
6. reset_n pulled low mid-GNT0 with no clock edge -> s_mem_valid, m0_mem_ready and grant are 0 immediately. After release with both requesting, m0 is granted first.
